// File: rtl/demux32_stream.sv
// ---------------------------------------------------------------------------
// demux32_stream
//
// 1-to-32 registered demultiplexer. One producer stream is steered to one of
// 32 output channels by a 5-bit select. Every channel owns a one-entry holding
// register (EMPTY/FULL, kept in out_valid[k]) with its own valid/ready
// handshake, so the 32 consumers drain independently of each other.
//
// Optional feature (compile-time macro):
//   DEMUX_BCAST_EN  - when defined, in_bcast=1 writes in_data into all 32
//                     channels at once. It is accepted only when every channel
//                     can take a word in the same cycle. When undefined,
//                     in_bcast is ignored and no broadcast logic is built.
//
// Parameters:
//   N           data width per channel in bits (N >= 1)
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   in_valid    producer presents a word on in_data
//   in_ready    demux takes the word this cycle (combinational)
//   in_sel      destination channel 0..31
//   in_data     word to route
//   in_bcast    broadcast request (DEMUX_BCAST_EN builds only)
//   out_valid   bit k: channel k holds a word
//   out_ready   bit k: consumer k takes its word this cycle
//   out_data    channel k is out_data[k*N +: N]
//   xfer_count  16-bit wrapping count of accepted input transfers
// ---------------------------------------------------------------------------
module demux32_stream #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_sel,
  input  logic [N-1:0]    in_data,
  input  logic            in_bcast,
  output logic [31:0]     out_valid,
  input  logic [31:0]     out_ready,
  output logic [32*N-1:0] out_data,
  output logic [15:0]     xfer_count
);

  // A channel can take a new word when it is empty or is being drained in
  // this same cycle (load and drain together keep full throughput).
  logic [31:0] slot_free;
  logic        bcast_mode;
  logic        accept;
  logic [31:0] load;

  assign slot_free = ~out_valid | out_ready;

`ifdef DEMUX_BCAST_EN
  assign bcast_mode = in_bcast;
`else
  // Port kept for a stable interface; intentionally left unconnected.
  logic unused_in_bcast;
  assign unused_in_bcast = in_bcast;
  assign bcast_mode      = 1'b0;
`endif

  // Broadcast waits until every channel is free; in_sel is ignored then.
  // in_ready never looks at in_valid.
  assign in_ready = bcast_mode ? (&slot_free) : slot_free[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      if (bcast_mode) load = '1;
      else            load[in_sel] = 1'b1;
    end
  end

  // ---- register stage: per-channel holding registers and transfer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= '0;
      out_data   <= '0;
      xfer_count <= '0;
    end else begin
      for (int k = 0; k < 32; k++) begin
        if (load[k]) begin
          out_valid[k]        <= 1'b1;
          out_data[k*N +: N]  <= in_data;
        end else if (out_ready[k]) begin
          // Drain leaves the data in place; only the valid flag drops.
          out_valid[k] <= 1'b0;
        end
      end
      // A broadcast is one transfer; the counter wraps silently.
      if (accept) xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule
